// File: rtl/floatdata_stream_ctrl_if.sv
// Bus bundle for floatdata_stream_ctrl: Avalon-MM slave port toward the CPU plus the
// valid/ready float stream toward the classifier datapath, and the frame interrupt.
interface floatdata_stream_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              irq;

    // slave: the sequencer itself; master: the CPU/datapath side driving it
    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_data, out_valid, out_last, irq
    );
    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_data, out_valid, out_last, irq
    );
endinterface

// File: rtl/floatdata_stream_ctrl.sv
// CPU-fed float FIFO drained onto a valid/ready stream; counts words per frame, tags the
// last word and raises a sticky frame_done (with optional irq) at every frame boundary.
module floatdata_stream_ctrl #(
    parameter int DATA_W    = 32,
    parameter int FIFO_AW   = 4,
    parameter int FRAME_LEN = 784,
    parameter int CNT_W     = 10
) (
    input logic                    clk,
    input logic                    reset_n,
    floatdata_stream_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fill;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  last_word, data_q, rdata, status;
    logic               enable, irq_en, overflow, frame_done, valid_q;
    logic               wr, push_req, push, pop, soft_clear, w1c;
    logic               empty, full, beat, last;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign push_req   = wr && (bus.address == 2'd0);
    assign soft_clear = wr && (bus.address == 2'd1) && bus.writedata[1];
    assign w1c        = wr && (bus.address == 2'd2);
    assign empty      = (fill == '0);
    assign full       = fill[FIFO_AW];
    assign beat       = valid_q & bus.out_ready;
    assign last       = valid_q && (count == LAST_IDX);

    // LOAD always has a word waiting; SEND refills on the beat unless the frame ends
    assign pop  = ~soft_clear &
                  ((state == LOAD) ||
                   ((state == SEND) && beat && !last && enable && !empty));
    assign push = push_req & (~full | pop);

    // NOTE: storage is never reset; only the pointers and fill define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.writedata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (soft_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            count     <= '0;
            last_word <= '0;
        end else if (soft_clear) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            count   <= '0;
        end else begin
            unique case (state)
                IDLE: if (enable && !empty) state <= LOAD;
                LOAD: begin
                    data_q  <= mem[rd_ptr];
                    valid_q <= 1'b1;
                    state   <= SEND;
                end
                SEND: if (beat) begin
                    count     <= count + 1'b1;
                    last_word <= data_q;
                    if (last) begin
                        valid_q <= 1'b0;
                        state   <= DONE;
                    end else if (enable && !empty) begin
                        data_q <= mem[rd_ptr];
                    end else begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable     <= 1'b0;
            irq_en     <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (wr && (bus.address == 2'd1)) begin
                enable <= bus.writedata[0];
                irq_en <= bus.writedata[2];
            end
            // a set in the same cycle as a write-1-to-clear wins
            if (soft_clear)                     overflow <= 1'b0;
            else if (push_req && full && !pop)  overflow <= 1'b1;
            else if (w1c && bus.writedata[2])   overflow <= 1'b0;
            if (soft_clear)                     frame_done <= 1'b0;
            else if (state == DONE)             frame_done <= 1'b1;
            else if (w1c && bus.writedata[3])   frame_done <= 1'b0;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        status                 = '0;
        status[0]              = empty;
        status[1]              = full;
        status[2]              = overflow;
        status[3]              = frame_done;
        status[4]              = (state != IDLE);
        status[FIFO_AW+16:16]  = fill;
        rdata                  = '0;
        unique case (bus.address)
            2'd0:    rdata = last_word;
            2'd1:    rdata = DATA_W'({irq_en, 1'b0, enable});
            2'd2:    rdata = status;
            default: rdata = DATA_W'(count);
        endcase
    end

    assign bus.readdata  = rdata;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last;
    assign bus.irq       = frame_done & irq_en;
endmodule

// File: tb/tb_floatdata_stream_ctrl.sv
// Directed bench for floatdata_stream_ctrl: CPU-side tasks push words and queue the expected
// beats; an independent monitor checks every accepted beat against that queue.
module tb_floatdata_stream_ctrl;
    localparam int FRAME_LEN = 784;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    floatdata_stream_ctrl_if #(.DATA_W(32)) bus ();

    floatdata_stream_ctrl #(
        .DATA_W(32), .FIFO_AW(4), .FRAME_LEN(FRAME_LEN), .CNT_W(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d              = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic drain(input bit rnd);
        logic [31:0] st;
        bit          done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            av_read(2'd2, st);
            if (st[0] && !st[4] && sb.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats still outstanding after 5000 cycles", sb.size());
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got out_data %h, expected no beat", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", bus.out_data, e.data);
                    check("beat_last", 32'(bus.out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] rd;
        int          run;
        int          sent;
        int          guard;

        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        av_read(2'd2, rd);
        check("por_status", rd, 32'h0000_0001);
        check("por_valid", 32'(bus.out_valid), 32'd0);

        // basic stream and two-cycle latency
        av_write(2'd1, 32'h1);
        bus.out_ready = 1'b1;
        expect_word(32'h3F80_0000, 1'b0);
        av_write(2'd0, 32'h3F80_0000);
        check("lat_t0_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
        check("lat_t2_data", bus.out_data, 32'h3F80_0000);
        tick();
        tick();
        av_read(2'd3, rd);
        check("basic_count", rd, 32'd1);
        av_read(2'd2, rd);
        check("basic_status", rd, 32'h0000_0001);
        av_read(2'd0, rd);
        check("basic_last_word", rd, 32'h3F80_0000);

        // back-to-back from a full FIFO
        av_write(2'd1, 32'h2);
        for (int i = 0; i < 16; i++) begin
            expect_word(32'h4100_0000 + i, 1'b0);
            av_write(2'd0, 32'h4100_0000 + i);
        end
        av_read(2'd2, rd);
        check("prefill_status", rd, 32'h0010_0002);
        av_write(2'd1, 32'h1);
        run = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) run++;
            else if (run > 0) break;
            tick();
        end
        check("b2b_run", 32'(run), 32'd16);
        av_read(2'd2, rd);
        check("b2b_status", rd, 32'h0000_0001);
        av_read(2'd3, rd);
        check("b2b_count", rd, 32'd16);

        // backpressure and overflow
        av_write(2'd1, 32'h3);
        bus.out_ready = 1'b0;
        expect_word(32'hC0A0_0000, 1'b0);
        av_write(2'd0, 32'hC0A0_0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", bus.out_data, 32'hC0A0_0000);
        end
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_word(32'h4200_0000 + i, 1'b0);
            av_write(2'd0, 32'h4200_0000 + i);
        end
        av_read(2'd2, rd);
        check("ovf_status", rd, 32'h0010_0016);
        av_write(2'd2, 32'h4);
        av_read(2'd2, rd);
        check("ovf_w1c_status", rd, 32'h0010_0012);
        drain(1'b0);

        // full frame with random backpressure
        av_write(2'd1, 32'h7);
        sent  = 0;
        guard = 0;
        while (sent < FRAME_LEN && guard < 20000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            av_read(2'd2, rd);
            if (rd[1]) begin
                tick();
            end else begin
                expect_word(32'h3C00_0000 + sent, sent == FRAME_LEN - 1);
                av_write(2'd0, 32'h3C00_0000 + sent);
                sent++;
            end
            guard++;
        end
        if (sent < FRAME_LEN) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_push_timeout: pushed %0d of %0d words", sent, FRAME_LEN);
        end
        drain(1'b1);
        av_read(2'd2, rd);
        check("frame_status", rd, 32'h0000_0009);
        check("frame_irq", 32'(bus.irq), 32'd1);
        av_read(2'd3, rd);
        check("frame_count", rd, 32'd0);
        for (int i = 0; i < 2; i++) begin
            expect_word(32'h3D00_0000 + i, 1'b0);
            av_write(2'd0, 32'h3D00_0000 + i);
        end
        drain(1'b1);
        av_read(2'd3, rd);
        check("next_frame_count", rd, 32'd2);
        av_read(2'd2, rd);
        check("sticky_done_status", rd, 32'h0000_0009);
        av_write(2'd2, 32'h8);
        av_read(2'd2, rd);
        check("done_w1c_status", rd, 32'h0000_0001);
        check("done_w1c_irq", 32'(bus.irq), 32'd0);

        // soft_clear while a word is presented and 8 are queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) av_write(2'd0, 32'h4300_0000 + i);
        av_read(2'd2, rd);
        check("pre_clear_status", rd, 32'h0008_0010);
        av_read(2'd3, rd);
        check("pre_clear_count", rd, 32'd2);
        check("pre_clear_valid", 32'(bus.out_valid), 32'd1);
        av_write(2'd1, 32'h3);
        check("clear_valid", 32'(bus.out_valid), 32'd0);
        av_read(2'd2, rd);
        check("clear_status", rd, 32'h0000_0001);
        av_read(2'd3, rd);
        check("clear_count", rd, 32'd0);
        av_read(2'd1, rd);
        check("ctrl_readback", rd, 32'h0000_0001);
        bus.out_ready = 1'b1;
        repeat (4) tick();

        // asynchronous reset in the middle of SEND
        bus.out_ready = 1'b0;
        av_write(2'd0, 32'hDEAD_BEEF);
        tick();
        tick();
        check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus.out_valid), 32'd0);
        check("rst_async_data", bus.out_data, 32'd0);
        check("rst_async_last", 32'(bus.out_last), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        av_read(2'd2, rd);
        check("rst_status", rd, 32'h0000_0001);
        av_read(2'd1, rd);
        check("rst_ctrl", rd, 32'd0);
        av_read(2'd3, rd);
        check("rst_count", rd, 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
